regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file used by the processor core.
- Adds configurable width/depth, same-cycle write-to-read bypass, a per-register busy scoreboard for pending long-latency producers, and a sequenced soft clear.
- Sits between decode (read/mark ports) and writeback (write port).

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), register index width; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 always reads 0, is never written and is never busy.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset (asserted at 0).
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_W  write index.
- data_writeReg  in  WIDTH  write data.
- ctrl_readRegA  in  ADDR_W  read index A.
- ctrl_readRegB  in  ADDR_W  read index B.
- data_readRegA  out  WIDTH  read data A (combinational).
- data_readRegB  out  WIDTH  read data B (combinational).
- ctrl_markBusy  in  1  mark ctrl_busyReg as awaiting a producer.
- ctrl_busyReg  in  ADDR_W  index to mark busy.
- busy_A  out  1  scoreboard state for ctrl_readRegA.
- busy_B  out  1  scoreboard state for ctrl_readRegB.
- ctrl_clear  in  1  request a soft clear of all registers.
- clear_active  out  1  high while the clear sequencer runs.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (ctrl_reset=0, asynchronous): all registers 0, all busy bits 0, sequencer IDLE, clear_active=0, clear_done=0. Takes effect immediately, including mid-clear, and aborts the clear.
- Write: on a rising edge with ctrl_writeEnable=1 and clear_active=0, reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0. A write to reg 0 with ZERO_REG=1 is dropped.
- Read: the read is combinational. If ctrl_writeEnable=1, clear_active=0, ctrl_writeReg==readIdx and the index is writable, data_writeWeg is bypassed to the output. Otherwise the stored value is returned. Reg 0 reads 0 when ZERO_REG=1.
- Mark: on a rising edge with ctrl_markBusy=1 and clear_active=0, busy[ctrl_busyReg] <= 1. Marking reg 0 is ignored when ZERO_REG=1.
- Mark and write to the same index in the same cycle: data is written and the busy bit ends at 1 (mark wins, because a new producer is issued).
- busy_A/busy_B = busy[idx], forced to 0 when:
  - a same-cycle write to idx is clearing the bit and no same-cycle mark targets idx (bypass-consistent), or
  - idx is reg 0 with ZERO_REG=1.
- Clear sequencer states: IDLE, CLEARING, DONE.
  - IDLE -> CLEARING when ctrl_clear=1 is sampled; idx counter <= 0.
  - CLEARING: each cycle reg[idx] <= 0, busy[idx] <= 0, idx++. After idx==DEPTH-1 -> DONE. clear_active=1 for exactly DEPTH cycles.
  - DONE: clear_done=1 for one cycle, then -> IDLE.
  - ctrl_clear is ignored outside IDLE.
- While clear_active=1:
  - writes and marks are dropped;
  - bypass is disabled;
  - reads return current storage, so already-cleared entries read 0.
- Counter wrap: idx is ADDR_W bits wide; the terminal compare is on DEPTH-1, and no wrap is relied upon.
- Latency: reads 0 cycles; writes/marks visible in storage next cycle (same cycle via bypass); clear DEPTH+1 cycles from request to clear_done.

Decomposition:
- Package regfile_pkg:
  - sequencer state enum (IDLE, CLEARING, DONE);
  - default WIDTH/DEPTH constants;
  - localparam ZERO_IDX = 0.
- One sub-module, regfile_clear_seq:
  - owns the state register and index counter;
  - outputs clear_active, clear_done, clr_idx and clr_en.
- Storage, bypass and scoreboard stay in regfile_sb.

Test Plan:
- Reset then read all indices -> data=0 and busy=0 everywhere. Assert ctrl_reset=0 mid-operation -> outputs 0 immediately, no clock required.
- Write reg 5 = 0xDEADBEEF with readA=5 in the same cycle -> data_readRegA=0xDEADBEEF that cycle and after. Write reg 0 = 0x1234 -> reg 0 reads 0.
- Mark reg 7 -> busy_A=1 (readA=7) next cycle. Write reg 7 = 0x55 -> busy_A=0 in the write cycle; data reads 0x55.
- Same-cycle mark and write on reg 9 (data 0xA5) -> reg 9 = 0xA5 and busy=1 afterwards.
- Load regs 1..31 with distinct values, pulse ctrl_clear -> clear_active high for 32 cycles, clear_done one pulse at cycle 33. A write issued to reg 3 during the clear is dropped. All registers read 0 and all busy bits are 0 at the end.
- Assert ctrl_reset=0 at cycle 10 of a clear -> clear_active=0 immediately, sequencer IDLE, all registers 0, no clear_done pulse.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the scoreboarded register file
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int ZERO_IDX  = 0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLEARING = 2'd1,
      DONE     = 2'd2
   } seq_state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback bus of the scoreboarded register file
interface regfile_sb_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              ctrl_writeEnable;
   logic [ADDR_W-1:0] ctrl_writeReg;
   logic [WIDTH-1:0]  data_writeReg;
   logic [ADDR_W-1:0] ctrl_readRegA;
   logic [ADDR_W-1:0] ctrl_readRegB;
   logic [WIDTH-1:0]  data_readRegA;
   logic [WIDTH-1:0]  data_readRegB;
   logic              ctrl_markBusy;
   logic [ADDR_W-1:0] ctrl_busyReg;
   logic              busy_A;
   logic              busy_B;
   logic              ctrl_clear;
   logic              clear_active;
   logic              clear_done;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_readRegA, ctrl_readRegB, ctrl_markBusy, ctrl_busyReg, ctrl_clear,
      input  data_readRegA, data_readRegB, busy_A, busy_B, clear_active, clear_done
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_readRegA, ctrl_readRegB, ctrl_markBusy, ctrl_busyReg, ctrl_clear,
      output data_readRegA, data_readRegB, busy_A, busy_B, clear_active, clear_done
   );
endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - walks every register index once to perform a soft clear
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              clear_req,
   output logic              clear_active,
   output logic              clear_done,
   output logic [ADDR_W-1:0] clr_idx,
   output logic              clr_en
);

   seq_state_t state;

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         state        <= IDLE;
         clr_idx      <= '0;
         clear_active <= 1'b0;
         clear_done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state        <= CLEARING;
                  clr_idx      <= '0;
                  clear_active <= 1'b1;
               end
            end
            CLEARING: begin
               // terminal compare rather than wrap detection keeps non-full index spaces safe
               if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                  state        <= DONE;
                  clear_active <= 1'b0;
                  clear_done   <= 1'b1;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               clear_done <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               clear_active <= 1'b0;
               clear_done   <= 1'b0;
            end
         endcase
      end
   end

   assign clr_en = (state == CLEARING);

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R1W register file with write bypass, busy scoreboard and soft clear
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = 1
) (
   input logic        clock,
   input logic        ctrl_reset,
   regfile_sb_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              clear_active;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_ok;
   logic              mk_ok;

   function automatic logic writable(input logic [ADDR_W-1:0] idx);
      return !((ZERO_REG != 0) && (idx == ADDR_W'(ZERO_IDX)));
   endfunction

   regfile_clear_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clear_seq (
      .clock        (clock),
      .ctrl_reset   (ctrl_reset),
      .clear_req    (bus.ctrl_clear),
      .clear_active (clear_active),
      .clear_done   (bus.clear_done),
      .clr_idx      (clr_idx),
      .clr_en       (clr_en)
   );

   assign bus.clear_active = clear_active;
   assign wr_ok = bus.ctrl_writeEnable && !clear_active && writable(bus.ctrl_writeReg);
   assign mk_ok = bus.ctrl_markBusy && !clear_active && writable(bus.ctrl_busyReg);

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else if (clr_en) begin
         regs[clr_idx] <= '0;
         busy[clr_idx] <= 1'b0;
      end else begin
         if (wr_ok) begin
            regs[bus.ctrl_writeReg] <= bus.data_writeReg;
            busy[bus.ctrl_writeReg] <= 1'b0;
         end
         // a mark issued alongside a write belongs to a newer producer, so it wins
         if (mk_ok) busy[bus.ctrl_busyReg] <= 1'b1;
      end
   end

   always_comb begin
      bus.data_readRegA = regs[bus.ctrl_readRegA];
      if (wr_ok && bus.ctrl_writeReg == bus.ctrl_readRegA) bus.data_readRegA = bus.data_writeReg;
      if (!writable(bus.ctrl_readRegA)) bus.data_readRegA = '0;

      bus.data_readRegB = regs[bus.ctrl_readRegB];
      if (wr_ok && bus.ctrl_writeReg == bus.ctrl_readRegB) bus.data_readRegB = bus.data_writeReg;
      if (!writable(bus.ctrl_readRegB)) bus.data_readRegB = '0;
   end

   always_comb begin
      bus.busy_A = busy[bus.ctrl_readRegA] && writable(bus.ctrl_readRegA);
      if (wr_ok && bus.ctrl_writeReg == bus.ctrl_readRegA &&
          !(mk_ok && bus.ctrl_busyReg == bus.ctrl_readRegA)) bus.busy_A = 1'b0;

      bus.busy_B = busy[bus.ctrl_readRegB] && writable(bus.ctrl_readRegB);
      if (wr_ok && bus.ctrl_writeReg == bus.ctrl_readRegB &&
          !(mk_ok && bus.ctrl_busyReg == bus.ctrl_readRegB)) bus.busy_B = 1'b0;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
module tb_regfile_sb;

   logic clock;
   logic ctrl_reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] model_reg  [32];
   logic        model_busy [32];

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        mk;
      logic [4:0]  breg;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ea;
      logic [31:0] eb;
      logic        eba;
      logic        ebb;
   } vec_t;

   vec_t tbl [15];

   regfile_sb_if #(.WIDTH(32), .DEPTH(32)) bus ();

   regfile_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input logic mk, input logic [4:0] breg,
                        input logic [4:0] ra, input logic [4:0] rb);
      bus.ctrl_writeEnable = we;
      bus.ctrl_writeReg    = wreg;
      bus.data_writeReg    = wdata;
      bus.ctrl_markBusy    = mk;
      bus.ctrl_busyReg     = breg;
      bus.ctrl_readRegA    = ra;
      bus.ctrl_readRegB    = rb;
   endtask

   // architectural effect of one clock edge outside a clear
   task automatic model_edge(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                             input logic mk, input logic [4:0] breg);
      if (we && wreg != 0) begin
         model_reg[wreg]  = wdata;
         model_busy[wreg] = 1'b0;
      end
      if (mk && breg != 0) model_busy[breg] = 1'b1;
   endtask

   task automatic model_zero();
      for (int i = 0; i < 32; i++) begin
         model_reg[i]  = '0;
         model_busy[i] = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_data(input int idx, input logic we, input int wreg,
                                            input logic [31:0] wdata);
      if (idx == 0) return 32'h0;
      if (we && wreg == idx) return wdata;
      return model_reg[idx];
   endfunction

   function automatic logic exp_busy(input int idx, input logic we, input int wreg,
                                     input logic mk, input int breg);
      if (idx == 0) return 1'b0;
      if (we && wreg == idx && !(mk && breg == idx)) return 1'b0;
      return model_busy[idx];
   endfunction

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         bus.ctrl_readRegA = 5'(i);
         bus.ctrl_readRegB = 5'(31 - i);
         #1;
         check({tag, "_data_a"}, bus.data_readRegA, 32'h0);
         check({tag, "_data_b"}, bus.data_readRegB, 32'h0);
         check({tag, "_busy_a"}, {31'h0, bus.busy_A}, 32'h0);
         check({tag, "_busy_b"}, {31'h0, bus.busy_B}, 32'h0);
      end
   endtask

   initial begin
      int act_cnt;
      int done_cnt;
      int done_at;
      logic we, mk;
      logic [4:0] wreg, breg, ra, rb;
      logic [31:0] wdata;

      tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
      tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1};
      tbl[6]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  5'd7,  5'd7,  32'h55,       32'h55,       1'b0, 1'b0};
      tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5,  32'h55,       32'hDEADBEEF, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 5'd9,  32'h000000A5, 1'b1, 5'd9,  5'd9,  5'd9,  32'hA5,       32'hA5,       1'b0, 1'b0};
      tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd7,  32'hA5,       32'h55,       1'b1, 1'b0};
      tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        32'hA5,       1'b0, 1'b1};
      tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'hA5,       1'b0, 1'b1};
      tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd12, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
      tbl[13] = '{1'b1, 5'd12, 32'h00000077, 1'b0, 5'd0,  5'd12, 5'd9,  32'h77,       32'hA5,       1'b0, 1'b1};
      tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd12, 32'h77,       32'h77,       1'b0, 1'b0};

      ctrl_reset = 1'b0;
      bus.ctrl_clear = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      model_zero();
      cyc();
      cyc();
      check("reset_clear_active", {31'h0, bus.clear_active}, 32'h0);
      check("reset_clear_done", {31'h0, bus.clear_done}, 32'h0);
      ctrl_reset = 1'b1;
      check_all_zero("reset");

      for (int i = 0; i < 15; i++) begin
         cyc();
         drive(tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].mk, tbl[i].breg, tbl[i].ra, tbl[i].rb);
         #1;
         check($sformatf("vec%0d_data_a", i), bus.data_readRegA, tbl[i].ea);
         check($sformatf("vec%0d_data_b", i), bus.data_readRegB, tbl[i].eb);
         check($sformatf("vec%0d_busy_a", i), {31'h0, bus.busy_A}, {31'h0, tbl[i].eba});
         check($sformatf("vec%0d_busy_b", i), {31'h0, bus.busy_B}, {31'h0, tbl[i].ebb});
         model_edge(tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].mk, tbl[i].breg);
      end

      for (int i = 0; i < 300; i++) begin
         cyc();
         we    = 1'($urandom_range(0, 1));
         mk    = ($urandom_range(0, 3) == 0);
         wreg  = 5'($urandom_range(0, 31));
         breg  = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
         ra    = ($urandom_range(0, 2) == 0) ? wreg : 5'($urandom_range(0, 31));
         rb    = ($urandom_range(0, 2) == 0) ? breg : 5'($urandom_range(0, 31));
         wdata = $urandom;
         drive(we, wreg, wdata, mk, breg, ra, rb);
         #1;
         check("rand_data_a", bus.data_readRegA, exp_data(int'(ra), we, int'(wreg), wdata));
         check("rand_data_b", bus.data_readRegB, exp_data(int'(rb), we, int'(wreg), wdata));
         check("rand_busy_a", {31'h0, bus.busy_A}, {31'h0, exp_busy(int'(ra), we, int'(wreg), mk, int'(breg))});
         check("rand_busy_b", {31'h0, bus.busy_B}, {31'h0, exp_busy(int'(rb), we, int'(wreg), mk, int'(breg))});
         model_edge(we, wreg, wdata, mk, breg);
      end

      for (int i = 1; i < 32; i++) begin
         cyc();
         drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h111, 1'b0, 5'd0, 5'd0, 5'd0);
         model_edge(1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h111, 1'b0, 5'd0);
      end
      cyc();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd0, 5'd0);
      model_edge(1'b0, 5'd0, 32'h0, 1'b1, 5'd20);
      cyc();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      bus.ctrl_clear = 1'b1;
      cyc();
      bus.ctrl_clear = 1'b0;
      act_cnt = 0;
      done_cnt = 0;
      done_at = -1;
      for (int c = 0; c < 40; c++) begin
         if (bus.clear_active) act_cnt++;
         if (bus.clear_done) begin
            done_cnt++;
            done_at = c;
         end
         if (c == 5) begin
            drive(1'b1, 5'd3, 32'h0000FFFF, 1'b1, 5'd4, 5'd3, 5'd20);
            #1;
            check("clear_no_bypass", bus.data_readRegA, 32'h0);
            check("clear_uncleared_read", bus.data_readRegB, model_reg[20]);
            check("clear_uncleared_busy", {31'h0, bus.busy_B}, 32'h1);
         end
         cyc();
         if (c == 5) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      end
      check("clear_active_cycles", 32'(act_cnt), 32'd32);
      check("clear_done_pulses", 32'(done_cnt), 32'd1);
      check("clear_done_cycle", 32'(done_at), 32'd32);
      check_all_zero("after_clear");
      model_zero();

      cyc();
      drive(1'b1, 5'd30, 32'h0000CAFE, 1'b1, 5'd31, 5'd0, 5'd0);
      cyc();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      bus.ctrl_clear = 1'b1;
      cyc();
      bus.ctrl_clear = 1'b0;
      for (int c = 0; c < 10; c++) cyc();
      bus.ctrl_readRegA = 5'd30;
      bus.ctrl_readRegB = 5'd31;
      #1;
      check("midclear_active", {31'h0, bus.clear_active}, 32'h1);
      check("midclear_data", bus.data_readRegA, 32'h0000CAFE);
      check("midclear_busy", {31'h0, bus.busy_B}, 32'h1);
      ctrl_reset = 1'b0;
      #1;
      check("async_reset_active", {31'h0, bus.clear_active}, 32'h0);
      check("async_reset_done", {31'h0, bus.clear_done}, 32'h0);
      check("async_reset_data", bus.data_readRegA, 32'h0);
      check("async_reset_busy", {31'h0, bus.busy_B}, 32'h0);
      cyc();
      ctrl_reset = 1'b1;
      act_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.clear_active) act_cnt++;
         if (bus.clear_done) done_cnt++;
         cyc();
      end
      check("abort_no_active", 32'(act_cnt), 32'd0);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check_all_zero("after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
